// File: rtl/id_inst_queue_if.sv
// Fetch-to-decode handshake bundle: fetch offers {pc, inst} on the in_* side
// and decode consumes the head entry on the out_* side.
interface id_inst_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_pc;
  logic [INST_W-1:0] in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_pc;
  logic [INST_W-1:0] out_inst;

  // queue side
  modport slave (
    input  in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_inst
  );

  // fetch/decode side
  modport master (
    output in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_inst
  );
endinterface

// File: rtl/id_inst_queue.sv
// Fetch->decode instruction FIFO, first-word-fall-through one cycle after push,
// no full bypass; branch flush may keep the oldest surviving entry (delay slot).
module id_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  id_inst_queue_if.slave   q,
  input  logic             flush,
  input  logic             flush_keep_one,
  output logic [CNT_W-1:0] count,
  output logic             stallreq
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [CNT_W-1:0]  remain;
  logic              push, pop, wr_en;

  assign q.in_ready  = (count != CNT_W'(DEPTH));
  assign q.out_valid = (count != '0);
  assign stallreq    = ~q.out_valid;
  assign q.out_pc    = q.out_valid ? pc_mem[rd_ptr]   : '0;
  assign q.out_inst  = q.out_valid ? inst_mem[rd_ptr] : '0;

  assign push   = q.in_valid & q.in_ready;
  assign pop    = q.out_valid & q.out_ready;
  assign rd_nxt = rd_ptr + PTR_W'(pop);
  assign remain = count - CNT_W'(pop);

  // A push survives a flush only when it becomes the sole delay-slot entry.
  assign wr_en = push & (~flush | (flush_keep_one & (remain == '0)));

  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr]   <= q.in_pc;
      inst_mem[wr_ptr] <= q.in_inst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush && !flush_keep_one) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else if (flush && remain != '0) begin
      rd_ptr <= rd_nxt;
      wr_ptr <= rd_nxt + PTR_W'(1);
      count  <= CNT_W'(1);
    end else if (flush) begin
      // Queue drained by this pop: rd_nxt already equals wr_ptr.
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PTR_W'(push);
      count  <= CNT_W'(push);
    end else begin
      rd_ptr <= rd_nxt;
      wr_ptr <= wr_ptr + PTR_W'(push);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
endmodule
